// File: rtl/qr73_sys_encoder.sv
// qr73_sys_encoder
// ----------------------------------------------------------------------------
// Systematic encoder for the (73,37) quadratic-residue code. It computes
// p(x) = m(x)*x^36 mod g(x), with g(x) = x^36 + G_LOW, one message bit per
// clock in a 36-stage LFSR. The result is presented as the codeword
// {msg, parity} behind a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   msg_valid  in   msg_in valid
//   msg_ready  out  encoder can accept a message (registered)
//   msg_in     in   [36:0] message, bit 36 = highest degree, shifted first
//   cw_valid   out  codeword valid (registered)
//   cw_ready   in   downstream accepts codeword
//   cw_out     out  [72:0] codeword, [72:36]=message, [35:0]=parity
//   busy       out  high while the parity is being shifted
//
// Optional build macro QR73_ENC_BITSTREAM_EN adds a serial view of the
// codeword, streamed MSB first while the parallel word is offered:
//   bit_valid  out  serial bit valid
//   bit_out    out  serial bit
//   bit_last   out  marks codeword bit 0
//   bit_ready  in   serial consumer accepts bit
// With the macro defined, the encoder returns to idle only after both the
// parallel handshake and the final serial handshake, in either order.
// ----------------------------------------------------------------------------
module qr73_sys_encoder #(
    parameter logic [35:0] G_LOW = 36'h5D37FD975,
    parameter int          MSG_W = 37,
    parameter int          PAR_W = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     msg_valid,
    output logic                     msg_ready,
    input  logic [MSG_W-1:0]         msg_in,
    output logic                     cw_valid,
    input  logic                     cw_ready,
    output logic [MSG_W+PAR_W-1:0]   cw_out,
    output logic                     busy
`ifdef QR73_ENC_BITSTREAM_EN
    ,
    output logic                     bit_valid,
    output logic                     bit_out,
    output logic                     bit_last,
    input  logic                     bit_ready
`endif
);

    localparam int         CW_W     = MSG_W + PAR_W;
    localparam logic [5:0] LAST_CNT = 6'(MSG_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One step of the division register: shift up one degree and fold the
    // x^36 term (feedback) back in through the low coefficients of g(x).
    function automatic logic [PAR_W-1:0] lfsr_step(input logic [PAR_W-1:0] s,
                                                   input logic             b);
        logic fb;
        fb = b ^ s[PAR_W-1];
        return {s[PAR_W-2:0], 1'b0} ^ (fb ? G_LOW : {PAR_W{1'b0}});
    endfunction

    state_t             state;
    logic [MSG_W-1:0]   msg_reg;
    logic [PAR_W-1:0]   lfsr;
    logic [PAR_W-1:0]   lfsr_nxt;
    logic [5:0]         cnt;
    logic               msg_bit;
    logic               cw_fire;
    logic               done_exit;
`ifdef QR73_ENC_BITSTREAM_EN
    logic [6:0]         bit_idx;
    logic               bit_fire;
`endif

    always_comb begin
        // Message bits are consumed highest degree first.
        msg_bit  = msg_reg[LAST_CNT - cnt];
        lfsr_nxt = lfsr_step(lfsr, msg_bit);
        cw_fire  = cw_valid & cw_ready;
`ifdef QR73_ENC_BITSTREAM_EN
        bit_fire = bit_valid & bit_ready;
        // A side that has already completed has dropped its valid, so each
        // term is true once that side is finished, now or earlier.
        done_exit = (~cw_valid | cw_fire) & (~bit_valid | (bit_fire & bit_last));
`else
        done_exit = cw_fire;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            msg_reg   <= '0;
            lfsr      <= '0;
            cnt       <= '0;
            msg_ready <= 1'b1;
            cw_valid  <= 1'b0;
            cw_out    <= '0;
            busy      <= 1'b0;
`ifdef QR73_ENC_BITSTREAM_EN
            bit_idx   <= 7'(CW_W - 1);
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            bit_last  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (msg_valid && msg_ready) begin
                        msg_reg   <= msg_in;
                        lfsr      <= '0;
                        cnt       <= '0;
                        msg_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    lfsr <= lfsr_nxt;
                    if (cnt == LAST_CNT) begin
                        // Last message bit: lfsr_nxt is the final parity.
                        busy     <= 1'b0;
                        cw_valid <= 1'b1;
                        cw_out   <= {msg_reg, lfsr_nxt};
                        state    <= DONE;
`ifdef QR73_ENC_BITSTREAM_EN
                        bit_idx   <= 7'(CW_W - 1);
                        bit_valid <= 1'b1;
                        bit_out   <= msg_reg[MSG_W-1];
                        bit_last  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end

                DONE: begin
                    if (cw_fire) begin
                        cw_valid <= 1'b0;
                    end
`ifdef QR73_ENC_BITSTREAM_EN
                    if (bit_fire) begin
                        if (bit_idx == 7'd0) begin
                            bit_valid <= 1'b0;
                            bit_last  <= 1'b0;
                        end else begin
                            bit_idx  <= bit_idx - 7'd1;
                            bit_out  <= cw_out[bit_idx - 7'd1];
                            bit_last <= (bit_idx == 7'd1);
                        end
                    end
`endif
                    if (done_exit) begin
                        msg_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    msg_ready <= 1'b1;
                    cw_valid  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qr73_sys_encoder.sv
// Bench for qr73_sys_encoder: directed literal codewords, latency, reset
// abort, backpressure, then randomized traffic against a polynomial long
// division reference and a syndrome check over the x^i mod g(x) columns.
module tb_qr73_sys_encoder;

    localparam logic [35:0] G = 36'h5D37FD975;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [36:0] msg_in;
    logic        cw_valid;
    logic        cw_ready;
    logic [72:0] cw_out;
    logic        busy;
`ifdef QR73_ENC_BITSTREAM_EN
    logic        bit_valid;
    logic        bit_out;
    logic        bit_last;
    logic        bit_ready;
`endif

    qr73_sys_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_in    (msg_in),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .cw_out    (cw_out),
        .busy      (busy)
`ifdef QR73_ENC_BITSTREAM_EN
        ,
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .bit_last  (bit_last),
        .bit_ready (bit_ready)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: long division of m(x)*x^36 by g(x) = x^36 + G.
    function automatic logic [35:0] ref_parity(input logic [36:0] m);
        logic [72:0] r;
        logic [72:0] g;
        r = {m, 36'd0};
        g = {36'd0, 1'b1, G};
        for (int i = 72; i >= 36; i--) begin
            if (r[i]) r = r ^ (g << (i - 36));
        end
        return r[35:0];
    endfunction

    // Syndrome over columns x^i mod g(x), i = 0..72.
    function automatic logic [35:0] syndrome(input logic [72:0] cw);
        logic [35:0] col;
        logic [35:0] s;
        col = 36'd1;
        s   = '0;
        for (int i = 0; i < 73; i++) begin
            if (cw[i]) s = s ^ col;
            col = col[35] ? ({col[34:0], 1'b0} ^ G) : {col[34:0], 1'b0};
        end
        return s;
    endfunction

    // ---------------- behavioural model (timeline of one transaction) -------
    logic        chk_en   = 1'b0;
    logic        exp_ready, exp_valid, exp_busy, m_wait;
    logic [72:0] exp_cw;
    logic [36:0] pend_msg;
    int          since;
    int          n_hs  = 0;
    int          n_acc = 0;
`ifdef QR73_ENC_BITSTREAM_EN
    logic        exp_bvalid;
    int          exp_idx;
`endif

    always @(posedge clk) begin
        if (rst) begin
            exp_ready = 1'b1;
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            exp_cw    = '0;
            since     = -1;
            m_wait    = 1'b0;
            chk_en    = 1'b1;
`ifdef QR73_ENC_BITSTREAM_EN
            exp_bvalid = 1'b0;
            exp_idx    = 72;
`endif
        end else if (since >= 0) begin
            since++;
            if (since == 37) begin
                exp_busy  = 1'b0;
                exp_valid = 1'b1;
                exp_cw    = {pend_msg, ref_parity(pend_msg)};
                since     = -1;
                m_wait    = 1'b1;
`ifdef QR73_ENC_BITSTREAM_EN
                exp_bvalid = 1'b1;
                exp_idx    = 72;
`endif
            end
        end else if (m_wait) begin
            if (exp_valid && cw_ready) begin
                exp_valid = 1'b0;
                n_acc++;
            end
`ifdef QR73_ENC_BITSTREAM_EN
            if (exp_bvalid && bit_ready) begin
                if (exp_idx == 0) exp_bvalid = 1'b0;
                else exp_idx--;
            end
            if (!exp_valid && !exp_bvalid) begin
`else
            if (!exp_valid) begin
`endif
                m_wait    = 1'b0;
                exp_ready = 1'b1;
            end
        end else if (exp_ready && msg_valid) begin
            pend_msg  = msg_in;
            since     = 0;
            exp_ready = 1'b0;
            exp_busy  = 1'b1;
            n_hs++;
        end
    end

    // ---------------- compare process ---------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("msg_ready", 73'(msg_ready), 73'(exp_ready));
            chk("cw_valid",  73'(cw_valid),  73'(exp_valid));
            chk("busy",      73'(busy),      73'(exp_busy));
            chk("cw_out",    cw_out,         exp_cw);
            if (cw_valid === 1'b1 && cw_ready === 1'b1)
                chk("syndrome", 73'(syndrome(cw_out)), 73'd0);
`ifdef QR73_ENC_BITSTREAM_EN
            chk("bit_valid", 73'(bit_valid), 73'(exp_bvalid));
            if (exp_bvalid) begin
                chk("bit_out",  73'(bit_out),  73'(exp_cw[exp_idx]));
                chk("bit_last", 73'(bit_last), 73'(exp_idx == 0));
            end
`endif
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [36:0] m);
        int h0;
        bit ok;
        h0 = n_hs;
        ok = 1'b0;
        msg_valid = 1'b1;
        msg_in    = m;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (n_hs != h0) begin
                ok = 1'b1;
                break;
            end
        end
        msg_valid = 1'b0;
        if (!ok) chk("send_timeout", 73'd0, 73'd1);
    endtask

    task automatic wait_cw();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cw_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("cw_timeout", 73'd0, 73'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (msg_ready === 1'b1 && exp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 73'd0, 73'd1);
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        logic [72:0] ref_cw;
        logic [63:0] r64;
        logic [36:0] m;
        int          n;
        int          acc0;
        int          target;
        int          budget;

        rst       = 1'b1;
        msg_valid = 1'b0;
        msg_in    = '0;
        cw_ready  = 1'b1;
`ifdef QR73_ENC_BITSTREAM_EN
        bit_ready = 1'b1;
`endif
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_cw_out", cw_out, 73'd0);
        chk("rst_ready",  73'(msg_ready), 73'd1);
        cyc();
        rst = 1'b0;

        // Hand-computed pins of the reference model.
        chk("model_p1", 73'(ref_parity(37'd1)), 73'(36'h5D37FD975));
        chk("model_p2", 73'(ref_parity(37'd2)), 73'(36'hBA6FFB2EA));
        chk("model_p0", 73'(ref_parity(37'd0)), 73'd0);

        // msg=1: latency and literal codeword.
        send(37'd1);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cw_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("latency", 73'(n), 73'd38);
        chk("cw_lit1", cw_out, {37'd1, 36'h5D37FD975});
        wait_idle();

        send(37'd2);
        wait_cw();
        chk("cw_lit2", cw_out, {37'd2, 36'hBA6FFB2EA});
        wait_idle();

        send(37'd0);
        wait_cw();
        chk("cw_lit0", cw_out, 73'd0);
        wait_idle();

        // Reset at cnt=10 aborts the transaction.
        send(37'h1_2345_6789);
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 73'(msg_ready), 73'd1);
        chk("abort_valid", 73'(cw_valid),  73'd0);
        chk("abort_cw",    cw_out,         73'd0);
        m = 37'h0A_BCDE_F012;
        send(m);
        wait_cw();
        chk("post_abort_cw", cw_out, {m, ref_parity(m)});
        wait_idle();

        // Backpressure for 20 cycles with msg_valid noise.
        cw_ready = 1'b0;
        m = 37'h15_5555_AAAA;
        send(m);
        wait_cw();
        ref_cw = cw_out;
        acc0   = n_acc;
        for (int i = 0; i < 20; i++) begin
            cyc();
            msg_valid = 1'($urandom);
            r64       = {$urandom, $urandom};
            msg_in    = r64[36:0];
            @(negedge clk);
            chk("bp_stable", cw_out, ref_cw);
            chk("bp_valid",  73'(cw_valid),  73'd1);
            chk("bp_ready",  73'(msg_ready), 73'd0);
        end
        cyc();
        msg_valid = 1'b0;
        cw_ready  = 1'b1;
        cyc();
        cw_ready = 1'b0;
        @(negedge clk);
        chk("bp_one_hs", 73'(n_acc - acc0), 73'd1);
        chk("bp_dropped", 73'(cw_valid), 73'd0);
`ifndef QR73_ENC_BITSTREAM_EN
        chk("bp_idle", 73'(msg_ready), 73'd1);
`endif
        cw_ready = 1'b1;
        wait_idle();

        // Randomized traffic.
`ifdef QR73_ENC_BITSTREAM_EN
        target = n_acc + 200;
`else
        target = n_acc + 1000;
`endif
        budget = 90000;
        while (n_acc < target && budget > 0) begin
            cyc();
            budget--;
            msg_valid = 1'($urandom);
            r64       = {$urandom, $urandom};
            msg_in    = r64[36:0];
            cw_ready  = ($urandom % 4) != 0;
`ifdef QR73_ENC_BITSTREAM_EN
            bit_ready = 1'($urandom);
`endif
        end
        if (n_acc < target) chk("random_budget", 73'(n_acc), 73'(target));

        msg_valid = 1'b0;
        cw_ready  = 1'b1;
        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
